// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin arbiter sharing one VGA adapter write port
// among four drawing clients, with a hold-time watchdog against hung owners.
module vga_write_arbiter #(
    parameter int unsigned MAX_HOLD = 1024,
    parameter int unsigned HOLD_W   = 11
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  done,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] color_in,
    input  logic [3:0]  wen_in,
    output logic [3:0]  grant,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  color_out,
    output logic        writeEn,
    output logic        busy,
    output logic        timeout_flag,
    output logic [1:0]  last_owner
);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e              state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;
    logic [1:0]          last_owner_q, last_owner_d;

    logic [1:0]          winner;
    logic                win_valid;
    logic                hold_at_max;

    assign hold_at_max = (hold_q == HOLD_W'(MAX_HOLD - 1));

    // Round-robin search starting at rr_ptr; scanning offsets high-to-low
    // lets the smallest offset with a request overwrite the others.
    always_comb begin
        logic [1:0] idx;
        idx       = 2'd0;
        winner    = rr_ptr_q;
        win_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr_q + 2'(i);
            if (req[idx]) begin
                winner    = idx;
                win_valid = 1'b1;
            end
        end
    end

    // Next-state logic for the IDLE/GRANT/RELEASE controller.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        hold_d       = hold_q;
        timeout_d    = timeout_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StGrant;
                    grant_d = 4'b0001 << winner;
                    owner_d = winner;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                // Client release (done or abort) takes precedence over timeout.
                if (done[owner_q] || !req[owner_q] || hold_at_max) begin
                    state_d      = StRelease;
                    grant_d      = 4'b0000;
                    last_owner_d = owner_q;
                    rr_ptr_d     = owner_q + 2'd1;
                    if (!done[owner_q] && req[owner_q]) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            grant_q      <= 4'b0000;
            owner_q      <= 2'd0;
            rr_ptr_q     <= 2'd0;
            hold_q       <= '0;
            timeout_q    <= 1'b0;
            last_owner_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_q       <= hold_d;
            timeout_q    <= timeout_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Pixel-stream mux: only the owner's slice reaches the adapter, and only in GRANT.
    always_comb begin
        x_out     = 8'd0;
        y_out     = 7'd0;
        color_out = 3'd0;
        writeEn   = 1'b0;
        if (state_q == StGrant) begin
            x_out     = x_in[8*owner_q +: 8];
            y_out     = y_in[7*owner_q +: 7];
            color_out = color_in[3*owner_q +: 3];
            writeEn   = wen_in[owner_q];
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q != StIdle);
    assign timeout_flag = timeout_q;
    assign last_owner   = last_owner_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: directed self-checking bench with a grant scoreboard.
module tb_vga_write_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] color_in;
    logic [3:0]  wen_in;
    logic [3:0]  grant;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  color_out;
    logic        writeEn;
    logic        busy;
    logic        timeout_flag;
    logic [1:0]  last_owner;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    vga_write_arbiter #(.MAX_HOLD(1024), .HOLD_W(11)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .done         (done),
        .x_in         (x_in),
        .y_in         (y_in),
        .color_in     (color_in),
        .wen_in       (wen_in),
        .grant        (grant),
        .x_out        (x_out),
        .y_out        (y_out),
        .color_out    (color_out),
        .writeEn      (writeEn),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .last_owner   (last_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, grant);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {28'd0, grant}, {28'd0, e});
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        resetn   = 1'b0;
        req      = 4'b0000;
        done     = 4'b0000;
        x_in     = '0;
        y_in     = '0;
        color_in = '0;
        wen_in   = 4'b0000;
        #2;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wen", writeEn, 1'b0);
        chk("rst_x", x_out, 8'd0);
        chk("rst_tflag", timeout_flag, 1'b0);
        chk("rst_last", last_owner, 2'd0);
        #4;
        resetn = 1'b1;
        tick();

        // Single client 2 transaction.
        x_in[16 +: 8]    = 8'd75;
        y_in[14 +: 7]    = 7'd108;
        color_in[6 +: 3] = 3'b010;
        x_in[0 +: 8]     = 8'd11;
        wen_in[2]        = 1'b1;
        req              = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        expect_grant("t1_grant");
        chk("t1_x", x_out, 8'd75);
        chk("t1_y", y_out, 7'd108);
        chk("t1_color", color_out, 3'b010);
        chk("t1_wen1", writeEn, 1'b1);
        wen_in[2] = 1'b0;
        #1;
        chk("t1_wen0", writeEn, 1'b0);
        wen_in[2] = 1'b1;
        repeat (4) tick();
        done[2] = 1'b1;
        tick();
        done[2] = 1'b0;
        req     = 4'b0000;
        chk("t1_rel_grant", grant, 4'b0000);
        chk("t1_rel_wen", writeEn, 1'b0);
        chk("t1_rel_x", x_out, 8'd0);
        chk("t1_rel_busy", busy, 1'b1);
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_last", last_owner, 2'd2);

        // All four requesting, 17-cycle ownership each.
        do_reset();
        wen_in = 4'b0000;
        req    = 4'b1111;
        for (int n = 0; n < 5; n++) exp_q.push_back(4'b0001 << (n % 4));
        tick();
        for (int n = 0; n < 5; n++) begin
            expect_grant("t2_grant");
            repeat (16) tick();
            chk("t2_hold", grant, 4'b0001 << (n % 4));
            done[n % 4] = 1'b1;
            tick();
            done = 4'b0000;
            chk("t2_gap1", grant, 4'b0000);
            tick();
            chk("t2_gap2", grant, 4'b0000);
            if (n == 4) req = 4'b0000;
            tick();
        end
        chk("t2_idle", busy, 1'b0);

        // Non-owner client 3 activity must not disturb owner 1 (rr_ptr is 1 here).
        x_in[8 +: 8]  = 8'd33;
        x_in[24 +: 8] = 8'd200;
        wen_in        = 4'b0000;
        req           = 4'b0010;
        exp_q.push_back(4'b0010);
        tick();
        expect_grant("t3_grant");
        wen_in[3] = 1'b1;
        done[3]   = 1'b1;
        req[3]    = 1'b1;
        #1;
        chk("t3_wen", writeEn, 1'b0);
        chk("t3_x", x_out, 8'd33);
        tick();
        chk("t3_hold1", grant, 4'b0010);
        done[3] = 1'b0;
        req[3]  = 1'b0;
        tick();
        chk("t3_hold2", grant, 4'b0010);
        chk("t3_x2", x_out, 8'd33);
        wen_in  = 4'b0000;
        done[1] = 1'b1;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        chk("t3_rel", grant, 4'b0000);
        tick();

        // Hung client 0 forced out by the watchdog; client 1 pending.
        do_reset();
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        tick();
        expect_grant("t4_grant0");
        repeat (1023) tick();
        chk("t4_last_hold", grant, 4'b0001);
        chk("t4_tflag_pre", timeout_flag, 1'b0);
        tick();
        chk("t4_forced", grant, 4'b0000);
        chk("t4_tflag", timeout_flag, 1'b1);
        tick();
        exp_q.push_back(4'b0010);
        tick();
        expect_grant("t4_grant1");
        req     = 4'b0100;
        done[1] = 1'b1;
        exp_q.push_back(4'b0100);
        tick();
        done = 4'b0000;
        tick();
        tick();
        expect_grant("t4_grant2");
        chk("t4_tflag_sticky", timeout_flag, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // Abort by owner, then done coinciding with the last hold cycle.
        do_reset();
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        expect_grant("t5_grant");
        repeat (3) tick();
        req = 4'b0000;
        tick();
        chk("t5_abort", grant, 4'b0000);
        chk("t5_abort_busy", busy, 1'b1);
        chk("t5_abort_tflag", timeout_flag, 1'b0);
        tick();
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        tick();
        expect_grant("t5_grant1");
        repeat (1023) tick();
        done[1] = 1'b1;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        chk("t5_done_rel", grant, 4'b0000);
        chk("t5_done_tflag", timeout_flag, 1'b0);
        tick();
        chk("t5_last", last_owner, 2'd1);

        // Asynchronous reset mid-GRANT (rr_ptr is 2 before the reset).
        req       = 4'b0100;
        wen_in[2] = 1'b1;
        exp_q.push_back(4'b0100);
        tick();
        expect_grant("t6_grant");
        chk("t6_wen", writeEn, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 4'b0000);
        chk("t6_rst_wen", writeEn, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        #2;
        resetn = 1'b1;
        wen_in = 4'b0000;
        req    = 4'b1010;
        exp_q.push_back(4'b0010);
        tick();
        expect_grant("t6_rr0");
        req = 4'b1000;
        tick();
        chk("t6_abort", grant, 4'b0000);
        tick();
        exp_q.push_back(4'b1000);
        tick();
        expect_grant("t6_grant3");
        chk("t6_tflag", timeout_flag, 1'b0);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
